// File: rtl/riscv_dmem_responder.sv
// Data-memory responder: word-organised SRAM with byte/halfword/word lanes, a fixed
// number of wait states, single-cycle acknowledges and fault flagging.
module riscv_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_data_out_i,
    input  logic        dmem_read_i,
    input  logic        dmem_write_i,
    input  logic [1:0]  dmem_size_i,
    output logic        dmem_read_ack_o,
    output logic        dmem_write_ack_o,
    output logic [31:0] dmem_data_in_o,
    output logic        dmem_error_o,
    output logic        busy_o
);
    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
    localparam logic [1:0]  SZ_BYTE   = 2'b00;
    localparam logic [1:0]  SZ_HALF   = 2'b01;
    localparam logic [1:0]  SZ_WORD   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane);
        logic [31:0] w;
        w = old_word;
        case (size)
            SZ_BYTE: w[{lane, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: w[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            SZ_WORD: w = wdata;
            default: w = old_word;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] extract_lanes(input logic [31:0] word,
                                                  input logic [1:0]  size,
                                                  input logic [1:0]  lane);
        logic [31:0] r;
        case (size)
            SZ_BYTE: r = {24'h00_0000, word[{lane, 3'b000} +: 8]};
            SZ_HALF: r = {16'h0000, word[{lane[1], 4'b0000} +: 16]};
            SZ_WORD: r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        rd_q, rd_d, wr_q, wr_d;
    logic        read_ack_q, read_ack_d, write_ack_q, write_ack_d, error_q, error_d, busy_q, busy_d;
    logic [31:0] data_in_q, data_in_d;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0] cur_addr_s, cur_wdata_s, offset_s, rd_word_s;
    logic [1:0]  cur_size_s, lane_s;
    logic        cur_rd_s, cur_wr_s, in_range_s, misalign_s, fault_s, enter_resp_s, mem_we_s;
    logic [AW-1:0] idx_s;

    // While idle the live request is decoded so a zero-wait access can commit on its acceptance edge
    assign cur_addr_s  = (state_q == ST_IDLE) ? dmem_addr_i     : addr_q;
    assign cur_wdata_s = (state_q == ST_IDLE) ? dmem_data_out_i : wdata_q;
    assign cur_size_s  = (state_q == ST_IDLE) ? dmem_size_i     : size_q;
    assign cur_rd_s    = (state_q == ST_IDLE) ? dmem_read_i     : rd_q;
    assign cur_wr_s    = (state_q == ST_IDLE) ? dmem_write_i    : wr_q;

    // Address decode and fault classification
    always_comb begin
        offset_s   = cur_addr_s - BASE_ADDR;
        lane_s     = offset_s[1:0];
        idx_s      = offset_s[AW+1:2];
        in_range_s = ({2'b00, offset_s[31:2]} < DEPTH_WORDS);
        case (cur_size_s)
            SZ_BYTE: misalign_s = 1'b0;
            SZ_HALF: misalign_s = lane_s[0];
            SZ_WORD: misalign_s = (lane_s != 2'b00);
            default: misalign_s = 1'b0;
        endcase
        fault_s   = (cur_size_s == 2'b11) | (cur_rd_s & cur_wr_s) | misalign_s | ~in_range_s;
        rd_word_s = mem_q[idx_s];
    end

    // Next-state logic and request capture
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        enter_resp_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dmem_read_i || dmem_write_i) begin
                    addr_d  = dmem_addr_i;
                    wdata_d = dmem_data_out_i;
                    size_d  = dmem_size_i;
                    rd_d    = dmem_read_i;
                    wr_d    = dmem_write_i;
                    if (WAIT_STATES == 32'd0) begin
                        state_d      = ST_RESP;
                        enter_resp_s = 1'b1;
                        cnt_d        = 4'd0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d      = ST_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Response outputs, computed on the edge entering RESP
    always_comb begin
        read_ack_d  = 1'b0;
        write_ack_d = 1'b0;
        error_d     = 1'b0;
        data_in_d   = data_in_q;
        if (enter_resp_s) begin
            read_ack_d  = cur_rd_s;
            write_ack_d = cur_wr_s & ~cur_rd_s;
            error_d     = fault_s;
            if (cur_rd_s && !fault_s) begin
                data_in_d = extract_lanes(rd_word_s, cur_size_s, lane_s);
            end else begin
                data_in_d = data_in_q;
            end
        end else begin
            data_in_d = data_in_q;
        end
        busy_d   = (state_d != ST_IDLE);
        mem_we_s = enter_resp_s & cur_wr_s & ~fault_s;
    end

    // Control and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'h0000_0000;
            wdata_q     <= 32'h0000_0000;
            size_q      <= 2'b00;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            read_ack_q  <= 1'b0;
            write_ack_q <= 1'b0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
            data_in_q   <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            read_ack_q  <= read_ack_d;
            write_ack_q <= write_ack_d;
            error_q     <= error_d;
            busy_q      <= busy_d;
            data_in_q   <= data_in_d;
        end
    end

    // Array write port: read-modify-write keeps untouched lanes
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[idx_s] <= merge_lanes(rd_word_s, cur_wdata_s, cur_size_s, lane_s);
        end
    end

    assign dmem_read_ack_o  = read_ack_q;
    assign dmem_write_ack_o = write_ack_q;
    assign dmem_error_o     = error_q;
    assign dmem_data_in_o   = data_in_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Randomised scoreboard bench: three responders (wait states 1, 0, 3) against a byte-level memory model.
module tb_riscv_dmem_responder;
    localparam int N = 3;

    logic clk = 1'b0;
    logic reset_n;
    logic [N-1:0][31:0] addr_v, wdata_v, din_v;
    logic [N-1:0][1:0]  size_v;
    logic [N-1:0]       rd_v, wr_v, rack_v, wack_v, err_v, busy_v;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        riscv_dmem_responder #(
            .DEPTH_WORDS(1024),
            .BASE_ADDR  ((g == 2) ? 32'h0000_0100 : 32'h0000_0000),
            .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .clk             (clk),
            .reset_n         (reset_n),
            .dmem_addr_i     (addr_v[g]),
            .dmem_data_out_i (wdata_v[g]),
            .dmem_read_i     (rd_v[g]),
            .dmem_write_i    (wr_v[g]),
            .dmem_size_i     (size_v[g]),
            .dmem_read_ack_o (rack_v[g]),
            .dmem_write_ack_o(wack_v[g]),
            .dmem_data_in_o  (din_v[g]),
            .dmem_error_o    (err_v[g]),
            .busy_o          (busy_v[g])
        );
    end

    typedef struct {
        int          k;
        logic        rack;
        logic        wack;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  mdl [N][4096];
    logic [31:0] last_load [N];
    int          checks = 0;
    int          errors = 0;

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    function automatic logic [31:0] base_of(input int k);
        return (k == 2) ? 32'h0000_0100 : 32'h0000_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed little-endian memory; a faulted access changes nothing
    function automatic exp_t model(input int k, input logic rd, input logic wr,
                                   input logic [1:0] size, input logic [31:0] addr,
                                   input logic [31:0] data);
        logic [31:0] off, v;
        int          nb;
        bit          fault;
        exp_t        e;
        off   = addr - base_of(k);
        nb    = 1 << size;
        fault = (size == 2'b11) || (rd && wr) || (off >= 32'd4096) || ((off % 32'(nb)) != 32'd0);
        if (!fault && wr) begin
            for (int i = 0; i < nb; i++) mdl[k][int'(off) + i] = data[8*i +: 8];
        end
        if (!fault && rd) begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl[k][int'(off) + i];
            last_load[k] = v;
        end
        e.k    = k;
        e.rack = rd;
        e.wack = wr && !rd;
        e.err  = fault;
        e.data = last_load[k];
        return e;
    endfunction

    task automatic do_req(input int k, input logic rd, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] data);
        int n, nb;
        bit got;
        @(negedge clk);
        addr_v[k] = addr; wdata_v[k] = data; size_v[k] = size; rd_v[k] = rd; wr_v[k] = wr;
        sb_q.push_back(model(k, rd, wr, size, addr, data));
        n = 0; nb = 0; got = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (busy_v[k]) nb++;
            if (rack_v[k] || wack_v[k]) got = 1;
        end
        chk("ack_latency", 32'(n), 32'(ws_of(k) + 1));
        chk("busy_cycles", 32'(nb), 32'(ws_of(k) + 1));
        if (!got) sb_q.delete();
        // master drops the request only after the edge that ends RESP
        @(posedge clk); #1;
        rd_v[k] = 1'b0; wr_v[k] = 1'b0;
        @(negedge clk);
        chk("idle_after_resp", 32'({busy_v[k], rack_v[k], wack_v[k]}), 32'h0);
    endtask

    // Monitor: every presented response is matched against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < N; k++) begin
            if (rack_v[k] || wack_v[k] || err_v[k]) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp: dut %0d responded with none outstanding", k);
                end else begin
                    e = sb_q.pop_front();
                    chk("resp_dut", 32'(k), 32'(e.k));
                    chk("read_ack", 32'(rack_v[k]), 32'(e.rack));
                    chk("write_ack", 32'(wack_v[k]), 32'(e.wack));
                    chk("error", 32'(err_v[k]), 32'(e.err));
                    chk("data_in", din_v[k], e.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, sz;
        logic [31:0] off;
        reset_n = 1'b0;
        addr_v = '0; wdata_v = '0; size_v = '0; rd_v = '0; wr_v = '0;
        for (int k = 0; k < N; k++) last_load[k] = 32'h0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("reset_flags", 32'({rack_v[k], wack_v[k], err_v[k], busy_v[k]}), 32'h0);
            chk("reset_data", din_v[k], 32'h0);
        end
        reset_n = 1'b1;

        for (int k = 0; k < N; k++)
            for (int w = 0; w < 64; w++)
                do_req(k, 1'b0, 1'b1, 2'b10, base_of(k) + 32'(4 * w), $urandom());

        do_req(0, 1'b0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF);
        do_req(0, 1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
        chk("load_deadbeef", din_v[0], 32'hDEADBEEF);
        do_req(0, 1'b0, 1'b1, 2'b10, 32'h20, 32'h11223344);
        do_req(0, 1'b0, 1'b1, 2'b00, 32'h22, 32'hFFFFFFAA);
        do_req(0, 1'b1, 1'b0, 2'b10, 32'h20, 32'h0);
        chk("byte_merge", din_v[0], 32'h11AA3344);
        do_req(0, 1'b1, 1'b0, 2'b00, 32'h22, 32'h0);
        chk("load_byte", din_v[0], 32'h000000AA);
        do_req(0, 1'b1, 1'b0, 2'b01, 32'h22, 32'h0);
        chk("load_half", din_v[0], 32'h000011AA);

        do_req(0, 1'b1, 1'b0, 2'b01, 32'h21, 32'h0);
        do_req(0, 1'b1, 1'b0, 2'b10, 32'h4000, 32'h0);
        do_req(0, 1'b0, 1'b1, 2'b11, 32'h20, 32'h0);
        do_req(0, 1'b1, 1'b1, 2'b10, 32'h20, 32'h0);
        chk("fault_keeps_data", din_v[0], 32'h000011AA);
        do_req(0, 1'b1, 1'b0, 2'b10, 32'h20, 32'h0);
        chk("fault_keeps_array", din_v[0], 32'h11AA3344);

        do_req(0, 1'b0, 1'b1, 2'b10, 32'hFFC, 32'h5A5A_1234);
        do_req(0, 1'b1, 1'b0, 2'b10, 32'hFFC, 32'h0);
        do_req(0, 1'b0, 1'b1, 2'b10, 32'h1000, 32'h0);
        do_req(2, 1'b1, 1'b0, 2'b10, 32'hFC, 32'h0);
        do_req(2, 1'b1, 1'b0, 2'b10, 32'hFFFF_FFFC, 32'h0);

        // reset while a store sits in its wait state
        @(negedge clk);
        addr_v[0] = 32'h40; wdata_v[0] = 32'hCAFEF00D; size_v[0] = 2'b10; wr_v[0] = 1'b1;
        @(negedge clk);
        chk("busy_in_wait", 32'(busy_v[0]), 32'h1);
        reset_n = 1'b0;
        wr_v[0] = 1'b0;
        #1;
        chk("midreset_flags", 32'({rack_v[0], wack_v[0], err_v[0], busy_v[0]}), 32'h0);
        chk("midreset_data", din_v[0], 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < N; k++) last_load[k] = 32'h0;
        do_req(0, 1'b1, 1'b0, 2'b10, 32'h40, 32'h0);

        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 80; i++) begin
                r   = $urandom_range(0, 9);
                sz  = $urandom_range(0, 2);
                off = 32'($urandom_range(0, 255));
                if (r == 0) begin
                    sz  = $urandom_range(1, 2);
                    off = off | 32'h1;
                end else begin
                    off = off & ~((32'h1 << sz) - 32'h1);
                end
                if (r == 1) off = 32'($urandom_range(4096, 65535));
                if (r == 2) sz = 3;
                if (r == 3) do_req(k, 1'b1, 1'b1, 2'(sz), base_of(k) + off, $urandom());
                else if ($urandom_range(0, 1) == 0)
                    do_req(k, 1'b1, 1'b0, 2'(sz), base_of(k) + off, 32'h0);
                else
                    do_req(k, 1'b0, 1'b1, 2'(sz), base_of(k) + off, $urandom());
            end
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_dmem_responder.md
Name: riscv_dmem_responder

Overview:
Data-memory slave serving load/store requests issued by the pipeline memory stage. Holds a word-organised on-chip SRAM model and applies byte/halfword/word lane handling. Inserts a configurable number of wait states, then returns single-cycle read/write acknowledges and right-aligned read data on dmem_data_in. Flags misaligned, out-of-range and malformed requests.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, >= 4)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (word aligned)
WAIT_STATES, 1, cycles between request acceptance and acknowledge (0..15)

Ports:
clk  input  1  clock
reset_n  input  1  reset
dmem_addr  input  32  byte address of request
dmem_data_out  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0])
dmem_read  input  1  load request, held by master until dmem_read_ack
dmem_write  input  1  store request, held by master until dmem_write_ack
dmem_size  input  2  access size: MEMOP_SIZE_BYTE=00, MEMOP_SIZE_HALFWORD=01, MEMOP_SIZE_WORD=10
dmem_read_ack  output  1  one-cycle pulse: load complete, dmem_data_in valid
dmem_write_ack  output  1  one-cycle pulse: store complete
dmem_data_in  output  32  load data, right-aligned, zero-filled above access width
dmem_error  output  1  one-cycle pulse coincident with the ack of a faulted request
busy  output  1  high in WAIT and RESP states

Behaviour:
- Reset reset_n, asynchronous, active-low; clock clk. On reset: state IDLE, dmem_read_ack=0, dmem_write_ack=0, dmem_error=0, dmem_data_in=0, busy=0, wait counter=0. Array contents not reset. Reset mid-transaction aborts it; a pending store not yet committed is dropped.
- FSM IDLE -> WAIT -> RESP -> IDLE.
  - IDLE: on an edge with dmem_read|dmem_write=1, latch addr, data, size, op; go WAIT with counter=WAIT_STATES. If WAIT_STATES=0, go directly to RESP.
  - WAIT: decrement counter each cycle; at counter==1, go RESP on next edge.
  - RESP: exactly one cycle; the relevant ack is 1; go IDLE. Requests are ignored in RESP; next acceptance is at the earliest on the edge ending the first IDLE cycle.
- Latency: request sampled at edge N -> ack high during cycle N+1+WAIT_STATES (WAIT_STATES=1: ack 2 cycles after acceptance edge).
- Store commit and load read occur on the edge entering RESP. dmem_data_in is registered there and holds its value until the next successful load completes. Stores and faulted loads leave it unchanged.
- Lane rules, word index = (addr-BASE_ADDR)>>2, lane = addr[1:0]:
  - byte: write data[7:0] into lane; read returns {24'b0, byte}.
  - halfword: lane must be 0 or 2; read returns {16'b0, half}.
  - word: lane must be 0.
  - Unwritten lanes are preserved (read-modify-write inside the array).
- Faults, each producing the normal ack plus dmem_error=1 with no array update and no dmem_data_in update:
  - misalignment
  - address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS)
  - dmem_size=11
  - dmem_read and dmem_write both 1. Only dmem_read_ack pulses for this case.
- Address offset arithmetic is 32-bit unsigned; wrap below BASE_ADDR is out of range.
- Only one outstanding transaction; no pipelining of requests.

Test Plan:
- WAIT_STATES=1: store word 32'hDEADBEEF @0x10, then load word @0x10 -> write_ack 2 cycles after acceptance; read_ack with dmem_data_in=32'hDEADBEEF, dmem_error=0.
- Byte lanes: word 0x11223344 @0x20, store byte 0xAA @0x22, load word -> 0x11AA3344; load byte @0x22 -> 0x000000AA; load half @0x22 -> 0x000011AA.
- Faults: load half @0x21, load word @0x4000 (DEPTH_WORDS=1024), size=11, read&write together -> each gets ack + dmem_error=1; array and dmem_data_in unchanged.
- Back-to-back: master holds dmem_read through ack then drops it -> exactly one read_ack per request, no second acceptance during RESP.
- WAIT_STATES=0 and 3: ack at acceptance+1 and +4 cycles; busy high for 1 and 4 cycles respectively.
- Reset asserted during WAIT of a store -> outputs return to reset values immediately; a later load of that address returns the old contents.
